// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory responder with independent read and write channels.
// Optional ready backpressure: define AXI_SLV_BACKPRESSURE_EN.
module axi_mem_slave #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] INIT_VAL  = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    output logic        proto_err
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0]   r_mem [MEM_DEPTH];
    wstate_t       r_wstate, w_wstate_nxt;
    rstate_t       r_rstate, w_rstate_nxt;
    logic          r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [AW-1:0] r_waddr, r_raddr;
    logic [7:0]    r_awlen, r_arlen;
    logic [8:0]    r_wcnt, r_rcnt;
    logic [31:0]   r_rdata;
    logic          r_rlast, r_proto_err;
    logic          w_bp_ok;
    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wfinal;
    logic [AW-1:0] w_ar_idx;
    logic          w_unused;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic [1:0]  r_stall;

    assign w_bp_ok = r_lfsr[0] || (r_stall == 2'd3);

    // Pseudo-random ready gating; never stalls more than three cycles in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr  <= 16'hACE1;
            r_stall <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (w_bp_ok || !(r_awready || r_wready || r_arready))
                r_stall <= 2'd0;
            else
                r_stall <= r_stall + 2'd1;
        end
    end
`else
    assign w_bp_ok = 1'b1;
`endif

    assign awready   = r_awready & w_bp_ok;
    assign wready    = r_wready & w_bp_ok;
    assign arready   = r_arready & w_bp_ok;
    assign bvalid    = r_bvalid;
    assign bresp     = 2'b00;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign rlast     = r_rlast;
    assign rresp     = 2'b00;
    assign proto_err = r_proto_err;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_b_hs   = r_bvalid && bready;
    assign w_ar_hs  = arvalid && arready;
    assign w_r_hs   = r_rvalid && rready;
    assign w_wfinal = (r_wcnt == {1'b0, r_awlen});
    assign w_ar_idx = araddr[AW+1:2];
    assign w_unused = ^{awburst, arburst, awaddr[31:AW+2], awaddr[1:0],
                        araddr[31:AW+2], araddr[1:0]};

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wfinal) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // State registers; handshake flags are decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waddr <= '0;
            r_awlen <= 8'd0;
            r_wcnt  <= 9'd0;
        end else if (w_aw_hs) begin
            r_waddr <= awaddr[AW+1:2];
            r_awlen <= awlen;
            r_wcnt  <= 9'd0;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + AW'(1);
            r_wcnt  <= r_wcnt + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[i] <= INIT_VAL;
        end else if (w_w_hs) begin
            for (int unsigned b = 0; b < 4; b++)
                if (wstrb[b]) r_mem[r_waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Read fetch: each accepted beat preloads the next word on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr <= '0;
            r_arlen <= 8'd0;
            r_rcnt  <= 9'd0;
            r_rdata <= 32'd0;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata <= r_mem[w_ar_idx];
            r_raddr <= w_ar_idx + AW'(1);
            r_arlen <= arlen;
            r_rcnt  <= 9'd0;
            r_rlast <= (arlen == 8'd0);
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_rdata <= r_mem[r_raddr];
                r_raddr <= r_raddr + AW'(1);
                r_rcnt  <= r_rcnt + 9'd1;
                r_rlast <= ((r_rcnt + 9'd1) == {1'b0, r_arlen});
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_proto_err <= 1'b0;
        else if ((w_aw_hs && awsize != 3'd2) || (w_ar_hs && arsize != 3'd2) ||
                 (w_w_hs && (wlast != w_wfinal)))
            r_proto_err <= 1'b1;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 responder (slave) backed by a word-addressed internal memory array; the counterpart of the packet-processing masters on the system interconnect.
- Accepts INCR write and read bursts of 1..256 beats and returns OKAY responses.
- Provides the legal-slave behaviour that the AXI protocol assertions on the master side are proven against.
- Doubles as the memory model in block-level benches.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; power of two.
- INIT_VAL, 32'h0, reset value of every memory word.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- awaddr  in  32  write burst start byte address
- awlen  in  8  write beats minus one
- awsize  in  3  beat size; only 2 (4 bytes) legal
- awburst  in  2  burst type; all values treated as INCR
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
- wlast  in  1  last write beat flag from master
- wvalid  in  1  W valid
- wready  out  1  W ready
- bresp  out  2  write response, always 2'b00
- bvalid  out  1  B valid
- bready  in  1  B ready
- araddr  in  32  read burst start byte address
- arlen  in  8  read beats minus one
- arsize  in  3  beat size; only 2 legal
- arburst  in  2  burst type; treated as INCR
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rdata  out  32  read data
- rresp  out  2  read response, always 2'b00
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset_n low, async): all ready/valid outputs 0; rdata 0; rlast 0; bresp/rresp 0; proto_err 0; all memory words = INIT_VAL; both FSMs idle.
  - Ready outputs rise on the first clk edge after release.
  - Reset mid-burst aborts the burst with no response.
- Addressing: word index = addr[log2(MEM_DEPTH)+1:2]; upper bits ignored, so accesses wrap modulo MEM_DEPTH. Each beat adds 4 to the address; the word index wraps from MEM_DEPTH-1 to 0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&&awready: latch address and awlen; clear beat counter; go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each wvalid&&wready writes the wstrb-enabled bytes and increments the beat counter (9-bit).
  - The final beat is the one where counter==latched awlen; the slave's own count decides, not wlast. That beat -> W_RESP.
  - wlast on a non-final beat, or wlast low on the final beat, sets proto_err; the burst still continues by count.
  - W_RESP: bvalid=1, bresp=0, held until bready. Then -> W_IDLE, with awready=1 the following cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&&arready: latch; rdata <= mem[start word]; next cycle rvalid=1 (1-cycle latency).
  - R_DATA: rdata, rlast and rvalid are held stable while !rready.
  - On each handshake, the next beat loads the next word in the same edge, so consecutive beats go out back-to-back.
  - rlast=1 exactly on beat index==arlen, so arlen=0 gives rlast on the first beat.
  - Handshake with rlast -> R_IDLE: rvalid=0, arready=1 the next cycle.
- Concurrency: the read and write channels are fully independent.
  - Same-edge read fetch and write to the same word: the read returns the old data.
  - AW accepted while a read is in progress, and vice versa, is legal.
- awsize/arsize != 2 sampled at an address handshake sets proto_err; the transfer proceeds as size 2.
- proto_err clears only on reset.

Optional Feature:
- Macro AXI_SLV_BACKPRESSURE_EN.
- Defined: awready, wready and arready are additionally ANDed with bit 0 of a 16-bit Fibonacci LFSR.
  - Taps 16,14,13,11; seed 16'hACE1; advances every cycle.
  - A stall counter forces ready=1 after 3 consecutive stalled cycles in a ready-capable state.
  - bvalid and rvalid are not delayed.
- Undefined: ready outputs follow FSM state only, as described in Behaviour.

Test Plan:
- Single write, then read: AW addr 0x10, awlen 0; W 0xDEADBEEF, wstrb 4'hF, wlast 1 -> bvalid the cycle after W handshake with bresp 0. AR 0x10, arlen 0 -> rvalid 1 cycle after AR handshake, rdata 0xDEADBEEF, rlast 1.
- 4-beat burst: write 0x1,0x2,0x3,0x4 at 0x20, rready tied 1 -> read returns 4 consecutive rvalid cycles, rlast on beat 3 only.
- Byte strobes: word 0x40 = 0xFFFFFFFF, then write 0x00000000 with wstrb 4'b0101 -> read 0xFF00FF00.
- R backpressure: read burst arlen 2 with rready low 3 cycles mid-beat-1 -> rdata/rlast/rvalid unchanged during stall; beats complete in order.
- Wrap and protocol error: MEM_DEPTH 256, write 2 beats at 0x3FC with wlast on beat 0 -> words 255 and 0 written; proto_err=1; bresp still 0.
- Reset mid-burst: assert reset_n low during W_DATA beat 1 -> all valids/readies 0 immediately; after release awready=1 in 1 cycle; no bvalid issued.
